// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the generator and checker ends of the link.
// Both ends call lfsr_feedback so they agree on the stream by construction.
package lfsr_pkg;

    localparam int              MAX_BITS     = 32;
    localparam int              DEFAULT_BITS = 5;
    localparam logic [4:0]      DEFAULT_TAPS = 5'b10100;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // Callers zero-extend narrower registers; unused upper bits contribute nothing.
    function automatic logic lfsr_feedback(input logic [MAX_BITS-1:0] state,
                                           input logic [MAX_BITS-1:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Purpose: self-synchronising checker for a Fibonacci LFSR bit stream; hunts, then flywheels.
// Latency: all outputs registered, visible the cycle after the accepting edge.
// Backpressure: none; a bit is accepted on every cycle bit_valid_i is high.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int              BITS           = DEFAULT_BITS,
    parameter logic [BITS-1:0] RESET_TAPS     = BITS'(DEFAULT_TAPS),
    parameter int              LOSS_THRESHOLD = 3
) (
    input  logic            clk,
    input  logic            reset_ni,
    input  logic [BITS-1:0] taps_i,
    input  logic            load_taps_i,
    input  logic            bit_valid_i,
    input  logic            bit_i,
    input  logic            clear_count_i,
    output logic            locked_o,
    output logic            error_o,
    output logic [7:0]      error_count_o,
    output logic [BITS-1:0] state_o
);

    localparam int FILL_W = $clog2(BITS + 1);

    chk_state_e        state_q, state_d;
    logic [BITS-1:0]   hist_q, hist_d;
    logic [BITS-1:0]   taps_q, taps_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [3:0]        consec_q, consec_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pred;

    assign pred = lfsr_feedback(MAX_BITS'(hist_q), MAX_BITS'(taps_q));

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= HUNT;
            hist_q   <= '0;
            taps_q   <= RESET_TAPS;
            fill_q   <= '0;
            consec_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            taps_q   <= taps_d;
            fill_q   <= fill_d;
            consec_q <= consec_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        taps_d   = taps_q;
        fill_d   = fill_q;
        consec_d = consec_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;

        if (load_taps_i) begin
            // The bit arriving with a tap reload is dropped; the new mask needs a fresh hunt.
            taps_d   = taps_i;
            state_d  = HUNT;
            fill_d   = '0;
            consec_d = '0;
        end else if (bit_valid_i) begin
            case (state_q)
                HUNT: begin
                    hist_d = {hist_q[BITS-2:0], bit_i};
                    if (fill_q == FILL_W'(BITS - 1)) begin
                        fill_d = '0;
                        if (hist_d != '0) begin
                            state_d  = LOCKED;
                            consec_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // Flywheel: history follows our own prediction so a bad bit cannot corrupt it.
                    hist_d = {hist_q[BITS-2:0], pred};
                    if (bit_i != pred) begin
                        err_d = 1'b1;
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                        if (consec_q == 4'(LOSS_THRESHOLD - 1)) begin
                            state_d  = HUNT;
                            fill_d   = '0;
                            consec_d = '0;
                        end else begin
                            consec_d = consec_q + 4'd1;
                        end
                    end else begin
                        consec_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clear_count_i) begin
            cnt_d = '0;
        end
    end

    assign locked_o      = (state_q == LOCKED);
    assign error_o       = err_q;
    assign error_count_o = cnt_q;
    assign state_o       = hist_q;

endmodule
